pwm_actuator: RTL
=================

# pwm_actuator

Downstream actuator stage of the fuzzy controller. It consumes the defuzzified control effort `G_out` (0..100 %) and converts it into a fixed-frequency PWM drive signal. The duty cycle is latched once per PWM period, clamped to 100 %, and optionally slew-rate limited. It also provides a soft-start whenever the block is enabled.

## Interface
Parameters:
- `CLK_DIV`, default 10: clocks per PWM step; must be ≥ 1. PWM period = 100·CLK_DIV clocks.
- `SLEW_STEP`, default 2: maximum duty change per period, in %; range 1..100. Used only when the slew feature is compiled in.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high; overrides every other input.
- `en`  in  1: run enable.
- `g_target`  in  8: requested duty in % (defuzz `G_out`), unsigned; values >100 are clamped to 100.
- `pwm_out`  out  1: registered PWM drive.
- `duty`  out  8: currently applied duty in %, 0..100.
- `period_start`  out  1: one-cycle pulse on every duty latch.
- `clamped`  out  1: set when the latched `g_target` exceeded 100; updated at each latch.

## Operation
- Internal registers:
  - `div_cnt`, counts 0..CLK_DIV-1.
  - `pwm_cnt`, counts 0..99.
  - `en_q`, the previous value of `en`.
- Step tick: `tick = en && div_cnt == CLK_DIV-1`.
- `div_cnt` wraps to 0 on `tick`; otherwise it increments while `en` is high.
- `pwm_cnt` advances on `tick` and wraps from 99 to 0.
- Latch event, `latch = start || wrap`:
  - `start = en && !en_q`.
  - `wrap = tick && pwm_cnt == 99`.
- On `start`, `div_cnt` and `pwm_cnt` are forced to 0.
- On `latch`:
  - Compute `tgt = min(g_target, 100)`.
  - `clamped <= (g_target > 100)`.
  - `duty <= next_duty(duty, tgt)`.
  - `period_start` pulses high for one cycle.
- `g_target` is sampled only in the latch cycle. Changes between latches are ignored.
- `pwm_out <= en && (pwm_cnt < duty)`, evaluated on the current register values:
  - duty 0 gives a constantly low output.
  - duty 100 gives a constantly high output.
  - High time per period = duty·CLK_DIV clocks.
- While `en` = 0:
  - `div_cnt`, `pwm_cnt`, `duty`, `pwm_out`, `period_start` are held at 0.
  - `clamped` holds its value.
  - Consequence: every re-enable soft-starts from duty 0.
- Arithmetic: all values are 8-bit unsigned and never exceed 100, so no overflow or underflow is possible. Comparisons are unsigned.

## Timing
- Reset value: every register is 0, including all outputs and `en_q`.
- Reset asserted mid-period: all registers are 0 on the following edge. After release with `en` = 1, the first edge sees `en_q` = 0, so a `start` latch occurs.
- Latency from `en` rising (sampled at edge N):
  - `duty` and `period_start` valid after edge N.
  - `pwm_out` reflects the new duty after edge N+1.
- `en` falling: `pwm_out` = 0 after the next edge. A partial period is abandoned, with no completion.
- `pwm_out` lags `pwm_cnt` by exactly one clock.
- Simultaneous `start` and `wrap` cannot occur, because `wrap` requires `en_q` = 1.
- CLK_DIV = 1: `tick` is high every enabled cycle and the period is 100 clocks.

## Configuration
- `PWM_SLEW_EN` defined:
  - `next_duty` moves `duty` toward `tgt` by `min(SLEW_STEP, |tgt − duty|)`.
  - Equal values hold.
- `PWM_SLEW_EN` undefined:
  - `next_duty = tgt`.
  - `SLEW_STEP` is unused.
- In both cases `en` = 0 forces duty to 0.

## Structure
- Shared package `fuzzy_pkg`:
  - `typedef logic [7:0] pct_t`.
  - `localparam pct_t G_MAX = 100`, also used by defuzz.
  - `localparam int PWM_STEPS = 100`.
- One combinational sub-module, `duty_slew`:
  - Inputs: `cur`, `tgt`; output: `nxt`; parameter `SLEW_STEP`.
  - Contains the `PWM_SLEW_EN` branch.
- Counters, latch logic and the output register live in `pwm_actuator`.

## Test plan
All scenarios use CLK_DIV = 2 and SLEW_STEP = 10 unless noted.
1. Reset, with `rst` high for 2 cycles and `en` = 1 → all outputs 0 while `rst` is high. On the first edge after release: `period_start` = 1 and `duty` latched.
2. Slew off, `en` = 1, `g_target` = 50 → `duty` = 50. `pwm_out` is high for exactly 100 consecutive clocks of each 200-clock period. `period_start` spacing is 200 clocks.
3. `PWM_SLEW_EN` defined, `g_target` = 35 from duty 0 → successive `period_start` latches give `duty` = 10, 20, 30, 35, 35. Changing `g_target` to 0 then gives 25, 15, 5, 0.
4. `g_target` = 200 → `duty` = 100, `clamped` = 1, and `pwm_out` stays high across the full period. Then `g_target` = 0 with slew off → `duty` = 0, `clamped` = 0, `pwm_out` stays low.
5. `en` dropped at `pwm_cnt` = 40 → `pwm_out` = 0 and `duty` = 0 on the next edge. Re-enable → `period_start` on the first edge, and the period restarts from `pwm_cnt` = 0.
6. `g_target` toggled between 20 and 80 mid-period → the applied `duty` changes only at `period_start`. The high-time count of each period matches the latched duty times 2.

Source files
------------

// File: rtl/fuzzy_pkg.sv
// Shared types for the fuzzy controller chain (defuzz output and PWM actuator).
package fuzzy_pkg;
  typedef logic [7:0] pct_t;
  localparam pct_t G_MAX     = 8'd100;
  localparam int   PWM_STEPS = 100;
endpackage

// File: rtl/duty_slew.sv
// Next-duty selection applied at each PWM latch.
// With PWM_SLEW_EN defined the duty steps toward the target by at most SLEW_STEP.
module duty_slew
  import fuzzy_pkg::*;
#(
  parameter int SLEW_STEP = 2
) (
  input  pct_t cur,
  input  pct_t tgt,
  output pct_t nxt
);
`ifdef PWM_SLEW_EN
  localparam pct_t STEP = pct_t'(SLEW_STEP);
  pct_t diff;
  logic up;

  always_comb begin
    up   = tgt > cur;
    diff = up ? tgt - cur : cur - tgt;
    if (diff > STEP) nxt = up ? cur + STEP : cur - STEP;
    else             nxt = tgt;
  end
`else
  logic unused_slew;
  assign unused_slew = ^{cur, pct_t'(SLEW_STEP)};
  assign nxt = tgt;
`endif
endmodule

// File: rtl/pwm_actuator.sv
// Fixed-frequency PWM drive from the defuzzified effort, duty latched once per period.
// Optional slew limiting of the latched duty is enabled by defining PWM_SLEW_EN.
module pwm_actuator
  import fuzzy_pkg::*;
#(
  parameter int CLK_DIV   = 10,
  parameter int SLEW_STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] g_target,
  output logic       pwm_out,
  output logic [7:0] duty,
  output logic       period_start,
  output logic       clamped
);
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam pct_t             PWM_LAST = pct_t'(PWM_STEPS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  pct_t pwm_cnt_q, pwm_cnt_d, duty_q, duty_d, duty_nxt, tgt;
  logic en_q, pwm_out_q, pwm_out_d, period_start_q, period_start_d, clamped_q, clamped_d;
  logic tick, start, wrap, latch;

  assign tgt = (g_target > G_MAX) ? G_MAX : g_target;

  duty_slew #(.SLEW_STEP(SLEW_STEP)) u_slew (
    .cur(duty_q),
    .tgt(tgt),
    .nxt(duty_nxt)
  );

  always_comb begin
    tick  = en && (div_cnt_q == DIV_LAST);
    start = en && !en_q;
    wrap  = tick && (pwm_cnt_q == PWM_LAST);
    latch = start || wrap;

    // Disabled: everything but clamped collapses to 0, so re-enable soft-starts.
    div_cnt_d      = '0;
    pwm_cnt_d      = '0;
    duty_d         = '0;
    pwm_out_d      = 1'b0;
    period_start_d = 1'b0;
    clamped_d      = clamped_q;
    if (en) begin
      if (!start) begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        pwm_cnt_d = !tick ? pwm_cnt_q : (wrap ? '0 : pwm_cnt_q + 1'b1);
      end
      duty_d         = latch ? duty_nxt : duty_q;
      clamped_d      = latch ? (g_target > G_MAX) : clamped_q;
      period_start_d = latch;
      pwm_out_d      = pwm_cnt_q < duty_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      duty_q         <= '0;
      en_q           <= 1'b0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      clamped_q      <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_q         <= duty_d;
      en_q           <= en;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      clamped_q      <= clamped_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign clamped      = clamped_q;
endmodule
